note_dispatcher: RTL

//  Sequencer feeding note_player: walks the song ROM for the selected song and issues notes.

---
 rtl/note_dispatcher_pkg.sv | 19 +
 rtl/note_dispatcher_wait_counter.sv | 36 +++
 rtl/note_dispatcher.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/note_dispatcher_pkg.sv
// Shared definitions for the song sequencer: FSM states and song-ROM entry kinds.
package note_dispatcher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic KIND_NOTE = 1'b0;
    localparam logic KIND_WAIT = 1'b1;

    // Note code 0 marks a rest entry that is skipped without issuing.
    localparam int unsigned NOTE_REST = 0;

endpackage

// File: rtl/note_dispatcher_wait_counter.sv
// Beat countdown for WAIT entries: load a duration, decrement on each counted beat, flag expiry.
module wait_counter #(
    parameter int unsigned DUR_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [DUR_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expire_o
);

    logic [DUR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Expiry is flagged on the beat that takes the count to zero, so the walk resumes next cycle.
    assign expire_o = dec_i && (cnt_q <= DUR_W'(1));

endmodule

// File: rtl/note_dispatcher.sv
// Song sequencer: walks the selected song in an external synchronous ROM and issues notes to note_player.
module note_dispatcher
    import note_dispatcher_pkg::*;
#(
    parameter int unsigned SONG_W = 2,
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned NOTE_W = 6,
    parameter int unsigned DUR_W  = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     play,
    input  logic                     new_song,
    input  logic [SONG_W-1:0]        song,
    input  logic                     beat,
    input  logic                     voice_free,
    output logic [SONG_W+IDX_W-1:0]  rom_addr,
    input  logic [NOTE_W+DUR_W:0]    rom_data,
    output logic                     load_new_note,
    output logic [NOTE_W-1:0]        note_to_load,
    output logic [DUR_W-1:0]         duration,
    output logic                     song_done
);

    localparam int unsigned KIND_POS = NOTE_W + DUR_W;

    logic              rom_kind;
    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;

    assign rom_kind = rom_data[KIND_POS];
    assign rom_note = rom_data[KIND_POS-1 -: NOTE_W];
    assign rom_dur  = rom_data[DUR_W-1:0];

    state_t             state_q, state_d;
    logic [SONG_W-1:0]  song_q, song_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NOTE_W-1:0]  note_f_q, note_f_d;
    logic [DUR_W-1:0]   dur_f_q, dur_f_d;
    logic [NOTE_W-1:0]  note_out_q, note_out_d;
    logic [DUR_W-1:0]   dur_out_q, dur_out_d;
    logic               done_q, done_d;
    logic               fire, advance, wc_load, wc_dec, wc_expire;

    wait_counter #(.DUR_W(DUR_W)) u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (new_song),
        .load_i     (wc_load),
        .load_val_i (rom_dur),
        .dec_i      (wc_dec),
        .expire_o   (wc_expire)
    );

    assign wc_dec = (state_q == ST_WAIT) && beat && play && !new_song;

    always_comb begin
        state_d    = state_q;
        song_d     = song_q;
        idx_d      = idx_q;
        note_f_d   = note_f_q;
        dur_f_d    = dur_f_q;
        note_out_d = note_out_q;
        dur_out_d  = dur_out_q;
        done_d     = 1'b0;
        fire       = 1'b0;
        advance    = 1'b0;
        wc_load    = 1'b0;

        if (new_song) begin
            song_d  = song;
            idx_d   = '0;
            state_d = play ? ST_FETCH : ST_IDLE;
        end else if (play) begin
            unique case (state_q)
                ST_IDLE:  state_d = ST_FETCH;
                ST_FETCH: state_d = ST_DECODE;
                ST_DECODE: begin
                    note_f_d = rom_note;
                    dur_f_d  = rom_dur;
                    if (rom_kind == KIND_NOTE) begin
                        if (rom_note != NOTE_W'(NOTE_REST))
                            state_d = ST_ISSUE;
                        else
                            advance = 1'b1;
                    end else if (rom_dur != '0) begin
                        state_d = ST_WAIT;
                        wc_load = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (voice_free) begin
                        fire       = 1'b1;
                        note_out_d = note_f_q;
                        dur_out_d  = dur_f_q;
                        advance    = 1'b1;
                    end
                end
                ST_WAIT:  advance = wc_expire;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase

            // The last entry ends the song instead of wrapping the index.
            if (advance) begin
                if (idx_q == '1) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            song_q     <= '0;
            idx_q      <= '0;
            note_f_q   <= '0;
            dur_f_q    <= '0;
            note_out_q <= '0;
            dur_out_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            song_q     <= song_d;
            idx_q      <= idx_d;
            note_f_q   <= note_f_d;
            dur_f_q    <= dur_f_d;
            note_out_q <= note_out_d;
            dur_out_q  <= dur_out_d;
            done_q     <= done_d;
        end
    end

    // Note/duration are presented combinationally with the pulse, then held from the output registers.
    assign rom_addr      = {song_q, idx_q};
    assign load_new_note = fire;
    assign note_to_load  = fire ? note_f_q : note_out_q;
    assign duration      = fire ? dur_f_q  : dur_out_q;
    assign song_done     = done_q;

endmodule
